// File: rtl/period_meter.sv
// Measures period and high time of an async input in i_clk cycles; strobe lands SYNC_STAGES+1 cycles after the edge.
// No backpressure: results hold until the next o_valid strobe, o_timeout is sticky until a valid period.
module period_meter #(
    parameter  int MAX_TICKS   = 1000000,
    parameter  int SYNC_STAGES = 2,
    localparam int W           = $clog2(MAX_TICKS + 1)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_sig,
    output logic [W-1:0] o_period,
    output logic [W-1:0] o_high,
    output logic         o_valid,
    output logic         o_timeout
);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    localparam logic [W-1:0] CNT_LAST = W'(MAX_TICKS - 1);
    localparam logic [W-1:0] CNT_ONE  = W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   s_sig;
    logic                   rise;
    logic                   fall;

    state_t         state_q,   state_d;
    logic [W-1:0]   cnt_q,     cnt_d;
    logic [W-1:0]   high_q,    high_d;
    logic [W-1:0]   period_q,  period_d;
    logic [W-1:0]   ohigh_q,   ohigh_d;
    logic           valid_q,   valid_d;
    logic           timeout_q, timeout_d;

    assign s_sig = sync_q[SYNC_STAGES-1];
    // Rise and fall share one synchronized bit, so they are mutually exclusive.
    assign rise  = s_sig & ~prev_q;
    assign fall  = ~s_sig & prev_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_sig};
            prev_q <= s_sig;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        high_d    = high_q;
        period_d  = period_q;
        ohigh_d   = ohigh_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    cnt_d   = '0;
                    high_d  = '0;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                // A rise on the last count wins over the timeout: period == MAX_TICKS.
                if (rise) begin
                    period_d  = cnt_q + CNT_ONE;
                    ohigh_d   = high_q;
                    valid_d   = 1'b1;
                    timeout_d = 1'b0;
                    cnt_d     = '0;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (fall) begin
                        high_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            high_q    <= '0;
            period_q  <= '0;
            ohigh_q   <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            high_q    <= high_d;
            period_q  <= period_d;
            ohigh_q   <= ohigh_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_period  = period_q;
    assign o_high    = ohigh_q;
    assign o_valid   = valid_q;
    assign o_timeout = timeout_q;

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: edge-time reference model feeds expected strobes/timeouts.
`timescale 1ns/1ps
module tb_period_meter;

    localparam int MAX  = 100;
    localparam int SYNC = 2;
    localparam int W    = $clog2(MAX + 1);

    logic         clk;
    logic         rst_n;
    logic         sig;
    logic [W-1:0] period;
    logic [W-1:0] high;
    logic         valid;
    logic         timeout;

    period_meter #(.MAX_TICKS(MAX), .SYNC_STAGES(SYNC)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_sig    (sig),
        .o_period (period),
        .o_high   (high),
        .o_valid  (valid),
        .o_timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int e;
        int p;
        int h;
    } exp_t;

    exp_t exp_q[$];
    int   to_q[$];
    int   obs_to_q[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference model state, in units of the posedge index that first samples a new i_sig value.
    bit armed  = 1'b0;
    int last_r = 0;
    int fall_t = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, expv);
        end
    endtask

    task automatic model_edge(input bit v, input int n);
        if (v) begin
            if (!armed) begin
                armed  = 1'b1;
                last_r = n;
            end else if (n - last_r <= MAX) begin
                exp_q.push_back('{n + SYNC, n - last_r, fall_t - last_r});
                last_r = n;
            end else begin
                to_q.push_back(last_r + MAX + SYNC);
                last_r = n;
            end
        end else if (armed) begin
            fall_t = n;
        end
    endtask

    // Must not be called exactly on a posedge so that cyc+1 names the sampling edge.
    task automatic set_sig(input bit v);
        if (v != sig) model_edge(v, cyc + 1);
        sig = v;
    endtask

    task automatic hold(input bit v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            set_sig(v);
        end
    endtask

    task automatic pulse(input int h, input int l);
        hold(1'b1, h);
        hold(1'b0, l);
    endtask

    task automatic check_zero_outputs();
        chk("rst_period",  int'(period),  0);
        chk("rst_high",    int'(high),    0);
        chk("rst_valid",   int'(valid),   0);
        chk("rst_timeout", int'(timeout), 0);
    endtask

    task automatic async_edge(input longint target, input bit v);
        #(target - longint'($time));
        set_sig(v);
    endtask

    // Monitor: pops expected strobes and pairs observed timeout assertions with model timeouts.
    initial begin
        exp_t x;
        int   last_p = 0;
        int   last_h = 0;
        bit   prev_to = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_p  = 0;
                last_h  = 0;
                prev_to = 1'b0;
            end else begin
                while (exp_q.size() != 0 && exp_q[0].e < cyc) begin
                    x = exp_q.pop_front();
                    chk("missing_strobe", cyc, x.e);
                end
                if (valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_strobe", 1, 0);
                    end else begin
                        x = exp_q.pop_front();
                        chk("strobe_cycle", cyc, x.e);
                        chk("period", int'(period), x.p);
                        chk("high", int'(high), x.h);
                        last_p = x.p;
                        last_h = x.h;
                    end
                    chk("timeout_clr_on_strobe", int'(timeout), 0);
                end
                if (timeout && !prev_to) begin
                    obs_to_q.push_back(cyc);
                    chk("period_hold_on_timeout", int'(period), last_p);
                    chk("high_hold_on_timeout", int'(high), last_h);
                end
                prev_to = timeout;
                while (to_q.size() != 0 && obs_to_q.size() != 0) begin
                    chk("timeout_cycle", obs_to_q.pop_front(), to_q.pop_front());
                end
            end
        end
    end

    initial begin
        int     p;
        int     h;
        int     j;
        longint base;
        rst_n = 1'b0;
        sig   = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs();
        rst_n = 1'b1;
        hold(1'b0, 5);

        // Square wave 10/4: first rise arms, then strobes every 10 cycles.
        repeat (9) pulse(4, 6);

        repeat (30) begin
            p = $urandom_range(2, MAX);
            h = $urandom_range(1, p - 1);
            pulse(h, p - h);
        end

        // Period exactly MAX, then MAX+1 (timeout), then re-arm and 20-cycle periods.
        pulse(40, 60);
        pulse(40, 61);
        pulse(10, 10);
        pulse(10, 10);
        pulse(10, 10);

        repeat (10) pulse(1, 1);

        // Reset partway through a 30/10 period.
        repeat (3) pulse(10, 20);
        hold(1'b1, 10);
        hold(1'b0, 6);
        rst_n = 1'b0;
        armed = 1'b0;
        @(negedge clk);
        check_zero_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hold(1'b0, 11);
        repeat (3) pulse(10, 20);

        // Asynchronous edges jittered around posedges, nominal period 50 / high 20.
        hold(1'b0, 5);
        @(posedge clk);
        base = longint'($time);
        for (int k = 0; k < 20; k++) begin
            j = $urandom_range(1, 4);
            if ($urandom_range(0, 1) == 1) j = -j;
            async_edge(base + 500 * longint'(k + 1) + longint'(j), 1'b1);
            j = $urandom_range(1, 4);
            if ($urandom_range(0, 1) == 1) j = -j;
            async_edge(base + 500 * longint'(k + 1) + 200 + longint'(j), 1'b0);
        end

        hold(1'b0, 20);
        chk("strobes_left", exp_q.size(), 0);
        chk("exp_timeouts_left", to_q.size(), 0);
        chk("obs_timeouts_left", obs_to_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
